// File: rtl/seq_array_div_if.sv
// seq_array_div_if
//   Pin bundle of the standard slot wrapper for the sequential divider.
//   ena     : always-1 enable from the wrapper (ignored by the core)
//   ui_in   : dividend N[7:0]
//   uio_in  : [3:0] divisor D, [4] start, [5] rsel, [7:6] unused
//   uo_out  : quotient, or {dbz, 3'b000, R[3:0]} when rsel=1
//   uio_out : [6] busy, [7] done, other bits 0
//   uio_oe  : output enables for the bidirectional pins
//   master  : the side that drives operands (testbench / wrapper)
//   slave   : the divider core
interface seq_array_div_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/seq_array_div.sv
// seq_array_div
//   Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit
//   per clock. A level start in IDLE or DONE captures N and D; eight RUN
//   cycles follow (one for divide-by-zero), then DONE holds the result.
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : slot pin bundle (slave side), see seq_array_div_if
module seq_array_div (
   input  logic           clk,
   input  logic           rst_n,
   seq_array_div_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_reg;
   logic [7:0] n_reg;
   logic [3:0] d_reg;
   logic [7:0] q_reg;
   logic [4:0] p_reg;
   logic [2:0] k_reg;
   logic       dbz_reg;
   logic       busy_reg;
   logic       done_reg;

   logic       start;
   logic       rsel;
   logic [2:0] bit_sel;
   logic [4:0] t_next;
   logic [4:0] diff;
   logic       fits;
   logic       unused_bits;

   assign start   = bus.uio_in[4];
   assign rsel    = bus.uio_in[5];

   // Dividend bits are consumed MSB first.
   assign bit_sel = 3'd7 - k_reg;
   // The 5th bit of T only carries the bit shifted out of P; after a
   // subtraction P < D <= 15, so P[4] is always zero between iterations.
   assign t_next  = {p_reg[3:0], n_reg[bit_sel]};
   assign diff    = t_next - {1'b0, d_reg};
   assign fits    = (t_next >= {1'b0, d_reg});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         n_reg     <= 8'h00;
         d_reg     <= 4'h0;
         q_reg     <= 8'h00;
         p_reg     <= 5'h00;
         k_reg     <= 3'd0;
         dbz_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  n_reg     <= bus.ui_in;
                  d_reg     <= bus.uio_in[3:0];
                  q_reg     <= 8'h00;
                  p_reg     <= 5'h00;
                  k_reg     <= 3'd0;
                  dbz_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
                  done_reg  <= 1'b0;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (d_reg == 4'h0) begin
                  // Divide by zero: saturate Q, pass the low nibble as R.
                  q_reg     <= 8'hFF;
                  p_reg     <= {1'b0, n_reg[3:0]};
                  dbz_reg   <= 1'b1;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  p_reg <= fits ? diff : t_next;
                  q_reg <= {q_reg[6:0], fits};
                  k_reg <= k_reg + 3'd1;
                  if (k_reg == 3'd7) begin
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.uo_out  = rsel ? {dbz_reg, 3'b000, p_reg[3:0]} : q_reg;
   assign bus.uio_out = {done_reg, busy_reg, 6'b00_0000};
   assign bus.uio_oe  = 8'b1100_0000;

   // Pins with no function in this design.
   assign unused_bits = &{1'b0, bus.ena, bus.uio_in[7:6], p_reg[4]};

endmodule

// File: tb/tb_seq_array_div.sv
module tb_seq_array_div;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] nv;
   logic [3:0] dv;
   logic       start;
   logic       rsel;

   seq_array_div_if bus ();

   assign bus.ena    = 1'b1;
   assign bus.ui_in  = nv;
   assign bus.uio_in = {2'b00, rsel, start, dv};

   seq_array_div dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] n;
      logic [3:0] d;
      logic [7:0] q;
      logic [7:0] r;
      int         busy_len;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launch on the next rising edge; returns at the falling edge after it.
   task automatic launch(input logic [7:0] n, input logic [3:0] d, input bit hold);
      @(negedge clk);
      nv    = n;
      dv    = d;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Counts busy cycles until done, bounded.
   task automatic wait_done(output int busy_cycles, output logic ok);
      busy_cycles = 0;
      for (int i = 0; i < 20 && bus.uio_out[7] !== 1'b1; i++) begin
         if (bus.uio_out[6] === 1'b1) busy_cycles++;
         @(negedge clk);
      end
      ok = bus.uio_out[7];
   endtask

   task automatic read_out(output logic [7:0] q, output logic [7:0] r);
      rsel = 1'b0;
      #1 q = bus.uo_out;
      rsel = 1'b1;
      #1 r = bus.uo_out;
      rsel = 1'b0;
   endtask

   initial begin
      int         bc;
      logic       ok;
      logic [7:0] q;
      logic [7:0] r;
      int         done_seen;

      vecs[0] = '{n: 8'd200,  d: 4'd13, q: 8'd15,  r: 8'h05, busy_len: 8};
      vecs[1] = '{n: 8'd77,   d: 4'd11, q: 8'd7,   r: 8'h00, busy_len: 8};
      vecs[2] = '{n: 8'd255,  d: 4'd1,  q: 8'd255, r: 8'h00, busy_len: 8};
      vecs[3] = '{n: 8'd7,    d: 4'd9,  q: 8'd0,   r: 8'h07, busy_len: 8};
      vecs[4] = '{n: 8'd0,    d: 4'd15, q: 8'd0,   r: 8'h00, busy_len: 8};
      vecs[5] = '{n: 8'h5A,   d: 4'd0,  q: 8'hFF,  r: 8'h8A, busy_len: 1};
      vecs[6] = '{n: 8'd10,   d: 4'd3,  q: 8'd3,   r: 8'h01, busy_len: 8};

      rst_n = 1'b0;
      nv    = 8'h00;
      dv    = 4'h0;
      start = 1'b0;
      rsel  = 1'b0;
      repeat (2) @(negedge clk);

      read_out(q, r);
      check("reset_q", q, 8'h00);
      check("reset_r", r, 8'h00);
      check("reset_uio_out", bus.uio_out, 8'h00);
      check("uio_oe", bus.uio_oe, 8'hC0);
      $display("reset: uo_out=%h/%h uio_out=%h", q, r, bus.uio_out);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         launch(vecs[i].n, vecs[i].d, 1'b0);
         wait_done(bc, ok);
         check("busy_len", bc, vecs[i].busy_len);
         check("done", ok, 1'b1);
         check("status_in_done", bus.uio_out, 8'h80);
         read_out(q, r);
         check("quotient", q, vecs[i].q);
         check("remainder", r, vecs[i].r);
         $display("op %0d: N=%0d D=%0d busy=%0d q=%h r=%h", i, vecs[i].n, vecs[i].d, bc, q, r);
      end

      // Inputs and start change mid-run; then start held for a relaunch.
      launch(8'd200, 4'd13, 1'b0);
      repeat (3) @(negedge clk);
      nv    = 8'd50;
      dv    = 4'd5;
      start = 1'b1;
      wait_done(bc, ok);
      check("midrun_busy_len", bc, 5);
      check("midrun_done", ok, 1'b1);
      read_out(q, r);
      check("midrun_q", q, 8'd15);
      check("midrun_r", r, 8'h05);
      $display("midrun change: q=%h r=%h", q, r);
      @(negedge clk);
      check("relaunch_status", bus.uio_out, 8'h40);
      wait_done(bc, ok);
      start = 1'b0;
      check("relaunch_busy_len", bc, 8);
      check("relaunch_done", ok, 1'b1);
      read_out(q, r);
      check("relaunch_q", q, 8'd10);
      check("relaunch_r", r, 8'h00);
      $display("relaunch: N=50 D=5 q=%h r=%h", q, r);

      // Reset in the third RUN cycle aborts the operation.
      launch(8'd200, 4'd13, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      read_out(q, r);
      check("abort_q", q, 8'h00);
      check("abort_r", r, 8'h00);
      check("abort_uio_out", bus.uio_out, 8'h00);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.uio_out !== 8'h00) done_seen++;
      end
      check("abort_stays_idle", done_seen, 0);
      $display("abort: q=%h r=%h status_hits=%0d", q, r, done_seen);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
